// File: rtl/less_or_equal_pkg.sv
// Shared constants and types for the less_or_equal comparator slice.
package less_or_equal_pkg;

  // Default operand width; legal widths are 2..64.
  localparam int WIDTH_DEFAULT = 32;
  localparam int WIDTH_MIN     = 2;
  localparam int WIDTH_MAX     = 64;

  // Encoding of the signed_mode input.
  typedef enum logic {
    CMP_UNSIGNED = 1'b0,
    CMP_SIGNED   = 1'b1
  } cmp_mode_e;

  localparam logic MODE_SIGNED   = 1'b1;
  localparam logic MODE_UNSIGNED = 1'b0;

  // One comparison result as it is latched into the output stage.
  typedef struct packed {
    logic le;    // a <= b
    logic lt;    // a <  b
    logic same;  // a == b (bitwise)
  } cmp_result_t;

  // Number of leaves in the comparator tree: smallest power of two >= n.
  // Bounded loop keeps this a plain constant function for elaboration.
  function automatic int leaf_count(input int n);
    int p;
    p = 1;
    for (int k = 0; k < 7; k++) begin
      if (p < n) p = p * 2;
    end
    return p;
  endfunction

endpackage

// File: rtl/less_or_equal_cmp_cell.sv
// Magnitude-compare merge cell: combines the (gt, eq) verdicts of two
// adjacent bit groups, the more significant group taking priority.
module cmp_cell (
  input  logic hi_gt,
  input  logic hi_eq,
  input  logic lo_gt,
  input  logic lo_eq,
  output logic gt,
  output logic eq
);

  // The upper group decides unless it is equal, then the lower group decides.
  always_comb begin
    gt = hi_gt | (hi_eq & lo_gt);
    eq = hi_eq & lo_eq;
  end

endmodule

// File: rtl/less_or_equal.sv
// Registered A <= B comparator with selectable signed/unsigned mode.
//
// Handshake: in_valid qualifies a, b and signed_mode on the rising edge of
// clk. There is no backpressure; one operation can be accepted per cycle.
// Exactly one cycle later out_valid is 1 for one cycle and eq/lt/same carry
// that result. When in_valid is 0 at an edge, out_valid drops to 0 and
// eq/lt/same keep their last values. Reset clears everything and discards
// any result in flight.
//
// The lower WIDTH-1 bits are compared by a balanced tree of cmp_cell merges
// (pure magnitude, no subtraction, so nothing can overflow). The MSB is then
// resolved separately: in unsigned mode it is just the top magnitude bit, in
// signed mode a differing MSB means the operand with MSB=1 is negative and
// therefore smaller.
module less_or_equal
  import less_or_equal_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             in_valid,
  output logic             eq,
  output logic             lt,
  output logic             same,
  output logic             out_valid
);

  // Bits below the MSB and the padded leaf count of the tree over them.
  localparam int LOW_BITS = WIDTH - 1;
  localparam int LEAVES   = leaf_count(LOW_BITS);

  // Heap-ordered tree: node 1 is the root, node i has children 2i (more
  // significant) and 2i+1 (less significant). Leaves sit at LEAVES..2*LEAVES-1
  // with bit j at index 2*LEAVES-1-j, so the leftmost leaf is the highest bit.
  logic node_gt [1:2*LEAVES-1];
  logic node_eq [1:2*LEAVES-1];

  cmp_mode_e   mode;
  logic        msb_a;
  logic        msb_b;
  logic        a_gt_b;
  logic        a_eq_b;
  cmp_result_t result;

  assign mode  = cmp_mode_e'(signed_mode);
  assign msb_a = a[WIDTH-1];
  assign msb_b = b[WIDTH-1];

  // Leaves: single-bit verdicts; padding leaves compare as equal so they
  // never influence the result.
  for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
    if (j < LOW_BITS) begin : g_bit
      assign node_gt[2*LEAVES-1-j] = a[j] & ~b[j];
      assign node_eq[2*LEAVES-1-j] = ~(a[j] ^ b[j]);
    end else begin : g_pad
      assign node_gt[2*LEAVES-1-j] = 1'b0;
      assign node_eq[2*LEAVES-1-j] = 1'b1;
    end
  end

  // Internal nodes: one merge cell per node, log2(LEAVES) levels deep.
  for (genvar i = 1; i < LEAVES; i++) begin : g_node
    cmp_cell u_cell (
      .hi_gt (node_gt[2*i]),
      .hi_eq (node_eq[2*i]),
      .lo_gt (node_gt[2*i+1]),
      .lo_eq (node_eq[2*i+1]),
      .gt    (node_gt[i]),
      .eq    (node_eq[i])
    );
  end

  // Resolve the MSB per mode and form the three result flags.
  always_comb begin
    a_gt_b = 1'b0;
    a_eq_b = 1'b0;
    if (msb_a != msb_b) begin
      // Unsigned: the set MSB is the larger. Signed: the set MSB is negative.
      a_gt_b = (mode == CMP_SIGNED) ? msb_b : msb_a;
      a_eq_b = 1'b0;
    end else begin
      a_gt_b = node_gt[1];
      a_eq_b = node_eq[1];
    end
    result.le   = ~a_gt_b;
    result.lt   = ~a_gt_b & ~a_eq_b;
    result.same = a_eq_b;
  end

  // Output stage: latch a fresh result on in_valid, otherwise hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq        <= 1'b0;
      lt        <= 1'b0;
      same      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        eq   <= result.le;
        lt   <= result.lt;
        same <= result.same;
      end
    end
  end

endmodule

// File: tb/tb_less_or_equal.sv
// Self-checking bench for less_or_equal: directed vectors with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_less_or_equal;
  import less_or_equal_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         signed_mode = 1'b0;
  logic         in_valid = 1'b0;
  logic         eq, lt, same, out_valid;

  less_or_equal #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .in_valid    (in_valid),
    .eq          (eq),
    .lt          (lt),
    .same        (same),
    .out_valid   (out_valid)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Output register contents as the rules define them: arithmetic compare
  // of the sampled operands, held when nothing is sampled, zero in reset.
  logic m_valid = 1'b0, m_le = 1'b0, m_lt = 1'b0, m_same = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_le = 1'b0; m_lt = 1'b0; m_same = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        m_same = (a == b);
        if (signed_mode) m_lt = ($signed(a) < $signed(b));
        else             m_lt = (a < b);
        m_le = m_lt || m_same;
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Entry: {has_literal, le, lt, same}; literal entries pin the model.
  logic [3:0] exp_q[$];

  always @(negedge clk) begin
    check("out_valid", out_valid, m_valid);
    check("eq",        eq,        m_le);
    check("lt",        lt,        m_lt);
    check("same",      same,      m_same);
    if (out_valid === 1'b1) begin
      check("inv_eq_lt_or_same", eq, lt | same);
      check("inv_lt_and_same",   lt & same, 1'b0);
      if (exp_q.size() == 0) begin
        check("result_without_request", 1'b1, 1'b0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (e[3]) begin
          check("lit_eq",   eq,   e[2]);
          check("lit_lt",   lt,   e[1]);
          check("lit_same", same, e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic mode, input logic v,
                       input logic has_lit, input logic l_le,
                       input logic l_lt, input logic l_same);
    @(negedge clk);
    a = ta; b = tb_v; signed_mode = mode; in_valid = v;
    if (v) exp_q.push_back({has_lit, l_le, l_lt, l_same});
  endtask

  task automatic lit(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                     input logic mode, input logic l_le, input logic l_lt,
                     input logic l_same);
    drive(ta, tb_v, mode, 1'b1, 1'b1, l_le, l_lt, l_same);
  endtask

  task automatic idle();
    drive($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [W-1:0] rnd_a, rnd_b;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_eq", eq, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;

    // Basic signed vectors
    lit(32'd1, 32'd2, MODE_SIGNED, 1, 1, 0);
    lit(32'd2, 32'd1, MODE_SIGNED, 0, 0, 0);
    lit(32'd0, 32'd0, MODE_SIGNED, 1, 0, 1);
    lit(32'd1, 32'd1, MODE_SIGNED, 1, 0, 1);
    lit(32'hFFFFFFFF, 32'hFFFFFFFF, MODE_SIGNED, 1, 0, 1);
    // Negatives and mixed signs
    lit(32'hFFFFFFFE, 32'hFFFFFFFF, MODE_SIGNED, 1, 1, 0);
    lit(32'hFFFFFFFF, 32'hFFFFFFFE, MODE_SIGNED, 0, 0, 0);
    lit(32'hFFFFFFFE, 32'd1,        MODE_SIGNED, 1, 1, 0);
    lit(32'hFFFFFFFF, 32'd2,        MODE_SIGNED, 1, 1, 0);
    lit(32'd2, 32'hFFFFFFFF,        MODE_SIGNED, 0, 0, 0);
    lit(32'd1, 32'hFFFFFFFE,        MODE_SIGNED, 0, 0, 0);
    // Unsigned vs signed on the same pair
    lit(32'hFFFFFFFF, 32'd1, MODE_UNSIGNED, 0, 0, 0);
    lit(32'd1, 32'hFFFFFFFF, MODE_UNSIGNED, 1, 1, 0);
    lit(32'hFFFFFFFF, 32'd1, MODE_SIGNED,   1, 1, 0);
    lit(32'd1, 32'hFFFFFFFF, MODE_SIGNED,   0, 0, 0);
    // Extremes
    lit(32'h80000000, 32'h7FFFFFFF, MODE_SIGNED,   1, 1, 0);
    lit(32'h7FFFFFFF, 32'h80000000, MODE_SIGNED,   0, 0, 0);
    lit(32'h80000000, 32'h7FFFFFFF, MODE_UNSIGNED, 0, 0, 0);
    lit(32'h80000000, 32'h80000000, MODE_UNSIGNED, 1, 0, 1);
    // Gap: out_valid drops, outputs hold the last result (1,1 equal)
    idle();
    @(negedge clk);
    check("gap_out_valid", out_valid, 1'b0);
    check("gap_hold_same", same, 1'b1);
    check("gap_hold_eq", eq, 1'b1);

    // Reset with a result pending: valid captured, then reset mid-cycle
    lit(32'd3, 32'd5, MODE_UNSIGNED, 1, 1, 0);
    @(posedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_eq", eq, 1'b0);
    check("rst_async_lt", lt, 1'b0);
    check("rst_async_out_valid", out_valid, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_lt", lt, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0: begin rnd_a = $urandom(); rnd_b = rnd_a; end
        1: begin rnd_a = 32'h80000000 | $urandom_range(0, 3); rnd_b = 32'h7FFFFFFC | $urandom_range(0, 3); end
        2: begin rnd_a = $urandom(); rnd_b = rnd_a ^ (32'd1 << $urandom_range(0, W-1)); end
        default: begin rnd_a = $urandom(); rnd_b = $urandom(); end
      endcase
      if ($urandom_range(0, 1)) begin
        drive(rnd_a, rnd_b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0), 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        drive(rnd_b, rnd_a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0), 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    idle();
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/less_or_equal.md
LESS_OR_EQUAL -- requirements
Module: less_or_equal

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronous to clk.
REQ-004 a  input  WIDTH  operand A, two's complement when signed_mode=1.
REQ-005 b  input  WIDTH  operand B, same encoding as a.
REQ-006 signed_mode  input  1  1 = signed compare, 0 = unsigned compare.
REQ-007 in_valid  input  1  a, b, signed_mode are sampled on this cycle.
REQ-008 eq  output  1  registered result, 1 when A <= B.
REQ-009 lt  output  1  registered result, 1 when A < B.
REQ-010 same  output  1  registered result, 1 when A == B.
REQ-011 out_valid  output  1  eq/lt/same hold a fresh result this cycle.

Function
REQ-012 Latency exactly 1 cycle: inputs sampled at edge N with in_valid=1 appear on outputs after edge N, with out_valid=1 for one cycle.
REQ-013 No backpressure; a new operation may be accepted every cycle.
REQ-014 When in_valid=0 at an edge, out_valid goes to 0 and eq/lt/same hold their previous values.
REQ-015 Invariants on every valid result: eq = lt OR same; lt AND same = 0.
REQ-016 Signed mode: operands are compared as two's complement; opposite signs are decided by MSB alone (negative < non-negative).
REQ-017 Unsigned mode: operands are compared as plain magnitudes (e.g. all-ones is the maximum).
REQ-018 same is independent of signed_mode (bitwise equality).
REQ-019 Extremes are exact: signed min <= signed max gives eq=1; max vs min gives eq=0; no overflow from any subtraction is permitted to corrupt the result.
REQ-020 Result is a pure function of the sampled inputs; no dependence on history.

Reset
REQ-021 While rst_n=0: eq=0, lt=0, same=0, out_valid=0, all within the same cycle as assertion.
REQ-022 Reset asserted mid-operation discards the in-flight result; first valid output after release requires a new in_valid.

Structure
REQ-023 Shared package holds WIDTH default constant and the encoding of signed_mode (SIGNED=1, UNSIGNED=0).
REQ-024 One sub-module, cmp_cell: 2-bit-group magnitude comparator producing (gt, eq) pair; less_or_equal builds a log2 tree of cmp_cell instances over the lower WIDTH-1 bits, then resolves the MSB per signed_mode.
REQ-025 Only the output stage (eq, lt, same, out_valid) is registered; the tree is combinational.

Verification
REQ-026 Signed, in_valid=1: (1,2)->eq=1,lt=1,same=0; (2,1)->eq=0,lt=0,same=0; (0,0)->eq=1,lt=0,same=1; (1,1) and (-1,-1)->eq=1,same=1.
REQ-027 Signed negatives and mixed signs: (-2,-1)->eq=1; (-1,-2)->eq=0; (-2,1)->eq=1; (-1,2)->eq=1; (2,-1)->eq=0; (1,-2)->eq=0.
REQ-028 Unsigned: (32'hFFFFFFFF,1)->eq=0; (1,32'hFFFFFFFF)->eq=1; same pair signed gives the opposite results.
REQ-029 Extremes, signed: (32'h80000000,32'h7FFFFFFF)->eq=1,lt=1; reversed ->eq=0.
REQ-030 Pipelining: back-to-back valid inputs on consecutive cycles produce back-to-back results one cycle later; an in_valid=0 gap yields out_valid=0 with held outputs.
REQ-031 Reset: assert rst_n=0 between clock edges with a result pending -> all outputs 0 immediately; after release, outputs stay 0 until the next in_valid.
